// File: rtl/hough_frame_loader.sv
// hough_frame_loader: validates a frame config, streams pixels into image BRAM, then starts the Hough core and tracks it to completion.
// Ports: clk/rst (async, active-high); cfg_width_i/cfg_height_i/cfg_threshold_i + load_req_i from host;
// pix_data_i/pix_valid_i/pix_ready_o pixel stream; bram_addr_o/bram_data_o/bram_we_o BRAM write port;
// width_o/height_o/threshold_o/start_o/core_ready_i core handshake; busy_o/done_o/err_o host status.
module hough_frame_loader #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8,
  parameter int DIM_W = 9,
  parameter int MAX_PIXELS = 131072
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIM_W-1:0]  cfg_width_i,
  input  logic [DIM_W-1:0]  cfg_height_i,
  input  logic [7:0]        cfg_threshold_i,
  input  logic              load_req_i,
  input  logic [DATA_W-1:0] pix_data_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  output logic [ADDR_W-1:0] bram_addr_o,
  output logic [DATA_W-1:0] bram_data_o,
  output logic              bram_we_o,
  output logic [DIM_W-1:0]  width_o,
  output logic [DIM_W-1:0]  height_o,
  output logic [7:0]        threshold_o,
  output logic              start_o,
  input  logic              core_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam logic [2:0] IDLE = 3'd0, CHECK = 3'd1, LOAD = 3'd2, ARM = 3'd3, WAIT_ACK = 3'd4, WAIT_DONE = 3'd5;
  localparam int TW = 2 * DIM_W;
  localparam logic [TW-1:0] MAX_TOT = TW'(MAX_PIXELS);
  logic [2:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [TW-1:0]     total, prod;
  logic              bad, acc, last;
  assign prod = TW'(width_o) * TW'(height_o);
  assign bad = width_o == '0 || height_o == '0 || prod > MAX_TOT;
  assign pix_ready_o = state == LOAD;
  assign busy_o = state != IDLE;
  assign acc = pix_valid_i & pix_ready_o;
  // total never exceeds MAX_PIXELS, so total-1 always fits the address width
  assign last = cnt == ADDR_W'(total - TW'(1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      total <= '0;
      bram_addr_o <= '0;
      bram_data_o <= '0;
      bram_we_o <= 1'b0;
      width_o <= '0;
      height_o <= '0;
      threshold_o <= '0;
      start_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      bram_we_o <= acc;
      start_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      if (acc) begin
        bram_addr_o <= cnt;
        bram_data_o <= pix_data_i;
        cnt <= cnt + ADDR_W'(1);
      end
      case (state)
        IDLE: if (load_req_i) begin
          width_o <= cfg_width_i;
          height_o <= cfg_height_i;
          threshold_o <= cfg_threshold_i;
          state <= CHECK;
        end
        CHECK: begin
          total <= prod;
          cnt <= '0;
          if (bad) begin
            err_o <= 1'b1;
            width_o <= '0;
            height_o <= '0;
            threshold_o <= '0;
            state <= IDLE;
          end else state <= LOAD;
        end
        LOAD: if (acc && last) state <= ARM;
        ARM: if (core_ready_i) begin
          start_o <= 1'b1;
          state <= WAIT_ACK;
        end
        WAIT_ACK: if (!core_ready_i) state <= WAIT_DONE;
        WAIT_DONE: if (core_ready_i) begin
          done_o <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hough_frame_loader.sv
// tb_hough_frame_loader: table-driven and directed checks of config rejection, pixel loading, core handshake and reset abort.
module tb_hough_frame_loader;
  logic        clk = 0, rst = 1;
  logic [8:0]  cfg_width_i = 0, cfg_height_i = 0;
  logic [7:0]  cfg_threshold_i = 0;
  logic        load_req_i = 0;
  logic [7:0]  pix_data_i = 0;
  logic        pix_valid_i = 0, pix_ready_o;
  logic [16:0] bram_addr_o;
  logic [7:0]  bram_data_o;
  logic        bram_we_o;
  logic [8:0]  width_o, height_o;
  logic [7:0]  threshold_o;
  logic        start_o, core_ready_i = 1, busy_o, done_o, err_o;
  logic [56:0] outs;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, exp_addr = 0, wr_cnt = 0, start_cnt = 0, done_cnt = 0, err_cnt = 0, bad = 0;
  int start_cyc = 0, last_wr_cyc = 0;
  bit prev_acc = 0;
  logic [7:0] prev_data = 0;

  hough_frame_loader dut (
    .clk(clk), .rst(rst), .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i),
    .cfg_threshold_i(cfg_threshold_i), .load_req_i(load_req_i), .pix_data_i(pix_data_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o), .bram_addr_o(bram_addr_o),
    .bram_data_o(bram_data_o), .bram_we_o(bram_we_o), .width_o(width_o), .height_o(height_o),
    .threshold_o(threshold_o), .start_o(start_o), .core_ready_i(core_ready_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  assign outs = {pix_ready_o, bram_addr_o, bram_data_o, bram_we_o, width_o, height_o,
                 threshold_o, start_o, busy_o, done_o, err_o};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write scoreboard: every write must follow an accepted beat by one cycle, with contiguous addresses
  always @(negedge clk) begin
    if (rst) begin
      prev_acc = 0;
      exp_addr = 0;
    end else begin
      if (load_req_i && !busy_o) begin
        exp_addr = 0; wr_cnt = 0; start_cnt = 0; done_cnt = 0; err_cnt = 0;
      end
      if (bram_we_o != prev_acc) bad++;
      if (bram_we_o) begin
        if (int'(bram_addr_o) != exp_addr || bram_data_o != prev_data) bad++;
        exp_addr++;
        wr_cnt++;
        last_wr_cyc = cyc;
      end
      if (start_o) begin start_cnt++; start_cyc = cyc; end
      if (done_o) done_cnt++;
      if (err_o) err_cnt++;
      prev_acc = pix_valid_i & pix_ready_o;
      prev_data = pix_data_i;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic start_frame(input int w, input int h, input int thr);
    cfg_width_i = 9'(w);
    cfg_height_i = 9'(h);
    cfg_threshold_i = 8'(thr);
    pix_valid_i = 0;
    load_req_i = 1;
    @(posedge clk); #1;
    load_req_i = 0;
  endtask

  task automatic load_pixels(input int n, input bit gap);
    int idx = 0, c = 0;
    bit a;
    while (idx < n && c < 400) begin
      pix_valid_i = !gap || (c % 2 == 0);
      pix_data_i = 8'(idx * 7 + 3);
      @(negedge clk);
      a = pix_valid_i & pix_ready_o;
      @(posedge clk); #1;
      if (a) idx++;
      c++;
    end
    pix_valid_i = 0;
    if (idx < n) check("load_timeout", idx, n);
  endtask

  task automatic finish_core(input int w, input int h, input int thr, input bit chk_lat);
    int n = 0;
    do begin @(negedge clk); n++; end while (!start_o && n < 100);
    check("start_seen", start_o, 1);
    check("width_o", width_o, w);
    check("height_o", height_o, h);
    check("threshold_o", threshold_o, thr);
    @(posedge clk); #1 core_ready_i = 0;
    @(negedge clk); check("busy_core", busy_o, 1);
    repeat (3) @(posedge clk);
    #1 core_ready_i = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!done_o && n < 100);
    check("done_seen", done_o, 1);
    @(negedge clk);
    check("idle_after_done", busy_o, 0);
    check("done_pulse", done_o, 0);
    check("hold_w", width_o, w);
    check("wr_cnt", wr_cnt, w * h);
    check("start_cnt", start_cnt, 1);
    check("done_cnt", done_cnt, 1);
    check("wr_order", bad, 0);
    if (chk_lat) check("start_lat", start_cyc, last_wr_cyc + 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1;
    #1 check("rst_outs", outs, 0);
    @(posedge clk); #1 rst = 0;
  endtask

  typedef struct { int w; int h; int thr; bit err; bit full; } vec_t;
  vec_t v[8];
  int rc;

  initial begin
    v[0] = '{0, 5, 1, 1'b1, 1'b0};
    v[1] = '{5, 0, 1, 1'b1, 1'b0};
    v[2] = '{511, 257, 9, 1'b1, 1'b0};
    v[3] = '{511, 256, 9, 1'b0, 1'b0};
    v[4] = '{2, 2, 255, 1'b0, 1'b1};
    v[5] = '{362, 362, 7, 1'b0, 1'b0};
    v[6] = '{4, 3, 10, 1'b0, 1'b1};
    v[7] = '{1, 1, 0, 1'b0, 1'b1};

    #1 check("reset_outs", outs, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    for (int i = 0; i < 8; i++) begin
      start_frame(v[i].w, v[i].h, v[i].thr);
      @(negedge clk); check("err_early", err_o, 0);
      @(negedge clk);
      check("err", err_o, v[i].err);
      check("accept", pix_ready_o, !v[i].err);
      check("width_lat", width_o, v[i].err ? 0 : v[i].w);
      @(posedge clk); #1;
      if (v[i].err) begin
        @(negedge clk);
        check("rej_idle", {busy_o, start_o, bram_we_o, err_o}, 0);
        check("rej_err_cnt", err_cnt, 1);
        check("rej_wr_cnt", wr_cnt, 0);
        check("rej_start_cnt", start_cnt, 0);
        @(posedge clk); #1;
      end else if (v[i].full) begin
        load_pixels(v[i].w * v[i].h, 0);
        finish_core(v[i].w, v[i].h, v[i].thr, 1);
      end else begin
        load_pixels(5, 0);
        do_reset;
      end
    end

    // valid toggling: ready must drop right after the final beat
    start_frame(4, 3, 10);
    @(posedge clk); #1;
    load_pixels(12, 1);
    pix_valid_i = 1;
    @(negedge clk); check("ready_after_last", pix_ready_o, 0);
    pix_valid_i = 0;
    finish_core(4, 3, 10, 1);

    // core busy at end of load: start must wait for ready
    start_frame(2, 2, 5);
    @(posedge clk); #1 core_ready_i = 0;
    load_pixels(4, 0);
    repeat (20) @(negedge clk);
    check("no_early_start", start_cnt, 0);
    check("busy_arm", busy_o, 1);
    @(posedge clk); #1 core_ready_i = 1;
    rc = cyc;
    finish_core(2, 2, 5, 0);
    check("start_after_ready", start_cyc, rc + 1);

    // load_req during LOAD is ignored
    start_frame(4, 3, 10);
    @(posedge clk); #1;
    load_pixels(5, 0);
    cfg_width_i = 7; cfg_height_i = 7; cfg_threshold_i = 99;
    load_req_i = 1;
    @(posedge clk); #1 load_req_i = 0;
    load_pixels(7, 0);
    check("ign_width", width_o, 4);
    check("ign_height", height_o, 3);
    finish_core(4, 3, 10, 1);

    // reset mid-frame, then a fresh frame restarts at address 0
    start_frame(4, 3, 10);
    @(posedge clk); #1;
    load_pixels(5, 0);
    do_reset;
    repeat (3) @(negedge clk);
    check("abort_no_start", start_o | bram_we_o | busy_o, 0);
    @(posedge clk); #1;
    start_frame(2, 2, 3);
    @(posedge clk); #1;
    load_pixels(4, 0);
    finish_core(2, 2, 3, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
